// File: rtl/ddr_cmd_pkg.sv
// Shared command-word layout for the DDR3 host interface: field positions,
// the decoded command struct and the decode helper.
package ddr_cmd_pkg;

  localparam int CMD_W     = 34;
  localparam int NUM_BANKS = 8;

  localparam int RANK_HI  = 33;
  localparam int RANK_LO  = 32;
  localparam int RW_BIT   = 31;
  localparam int RSV0_BIT = 30;
  localparam int ROW_HI   = 29;
  localparam int ROW_LO   = 17;
  localparam int RSV1_BIT = 16;
  localparam int BL_BIT   = 15;
  localparam int RSV2_BIT = 14;
  localparam int AP_BIT   = 13;
  localparam int COL_HI   = 12;
  localparam int COL_LO   = 3;
  localparam int BANK_HI  = 2;
  localparam int BANK_LO  = 0;

  typedef struct packed {
    logic [1:0]  rank;
    logic        write;
    logic [12:0] row;
    logic [9:0]  col;
    logic [2:0]  bank;
    logic        bl8;
    logic        auto_pre;
  } cmd_t;

  localparam int CMD_T_W = $bits(cmd_t);

  // rw=0 on the wire means write, so the struct's write flag is inverted.
  function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] c);
    cmd_t d;
    d.rank     = c[RANK_HI:RANK_LO];
    d.write    = ~c[RW_BIT];
    d.row      = c[ROW_HI:ROW_LO];
    d.col      = c[COL_HI:COL_LO];
    d.bank     = c[BANK_HI:BANK_LO];
    d.bl8      = c[BL_BIT];
    d.auto_pre = c[AP_BIT];
    return d;
  endfunction

  function automatic logic has_rsvd(input logic [CMD_W-1:0] c);
    return c[RSV0_BIT] | c[RSV1_BIT] | c[RSV2_BIT];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through FIFO; dout always shows the oldest entry.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Storage is cleared on reset so the head outputs are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ddr_cmd_intake.sv
// Host command intake: per-bank admission flags, in-order command queue with
// write data, sticky error flags and a registered read-data return path.
module ddr_cmd_intake
  import ddr_cmd_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 8,
  parameter int BANK_CAP = 4
) (
  input  logic              clk,
  input  logic              power_on_rst_n,
  input  logic [CMD_W-1:0]  command,
  input  logic [DATA_W-1:0] write_data,
  input  logic              valid,
  output logic [7:0]        ba_cmd_pm,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [1:0]        q_rank,
  output logic              q_write,
  output logic [12:0]       q_row,
  output logic [9:0]        q_col,
  output logic [2:0]        q_bank,
  output logic              q_bl8,
  output logic              q_auto_pre,
  output logic [DATA_W-1:0] q_wdata,
  input  logic [DATA_W-1:0] rdata_in,
  input  logic              rdata_in_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              read_data_valid,
  output logic [1:0]        cmd_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = CMD_T_W + DATA_W;

  logic [CW-1:0]     bank_cnt_q [NUM_BANKS];
  logic [CW-1:0]     bank_cnt_d [NUM_BANKS];
  logic [1:0]        cmd_err_q, cmd_err_d;
  logic [DATA_W-1:0] read_data_q;
  logic              read_data_valid_q;

  cmd_t              in_cmd, head_cmd;
  logic [DATA_W-1:0] in_wdata;
  logic [EW-1:0]     fifo_din, fifo_dout;
  logic              fifo_full, fifo_empty;
  logic              push, drop, pop;

  assign in_cmd   = decode_cmd(command);
  assign in_wdata = in_cmd.write ? write_data : {DATA_W{1'b0}};
  assign fifo_din = {in_cmd, in_wdata};

  // Admission depends only on flops, so the host sees no path from its own inputs.
  always_comb begin
    ba_cmd_pm = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ba_cmd_pm[b] = ~fifo_full && (bank_cnt_q[b] < CW'(BANK_CAP));
    end
  end

  assign push    = valid &  ba_cmd_pm[in_cmd.bank];
  assign drop    = valid & ~ba_cmd_pm[in_cmd.bank];
  assign q_valid = ~fifo_empty;
  assign pop     = q_valid & q_ready;

  cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_cmd   = cmd_t'(fifo_dout[EW-1:DATA_W]);
  assign q_rank     = head_cmd.rank;
  assign q_write    = head_cmd.write;
  assign q_row      = head_cmd.row;
  assign q_col      = head_cmd.col;
  assign q_bank     = head_cmd.bank;
  assign q_bl8      = head_cmd.bl8;
  assign q_auto_pre = head_cmd.auto_pre;
  assign q_wdata    = fifo_dout[DATA_W-1:0];

  always_comb begin
    bank_cnt_d = bank_cnt_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if ((push && in_cmd.bank == 3'(b)) && !(pop && head_cmd.bank == 3'(b))) begin
        bank_cnt_d[b] = bank_cnt_q[b] + CW'(1);
      end else if (!(push && in_cmd.bank == 3'(b)) && (pop && head_cmd.bank == 3'(b))) begin
        bank_cnt_d[b] = bank_cnt_q[b] - CW'(1);
      end
    end
    cmd_err_d = cmd_err_q;
    if (drop)                       cmd_err_d[0] = 1'b1;
    if (push && has_rsvd(command))  cmd_err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_cnt_q[b] <= '0;
      cmd_err_q         <= '0;
      read_data_q       <= '0;
      read_data_valid_q <= 1'b0;
    end else begin
      bank_cnt_q        <= bank_cnt_d;
      cmd_err_q         <= cmd_err_d;
      read_data_q       <= rdata_in;
      read_data_valid_q <= rdata_in_valid;
    end
  end

  assign cmd_err         = cmd_err_q;
  assign read_data       = read_data_q;
  assign read_data_valid = read_data_valid_q;

endmodule

// File: tb/tb_ddr_cmd_intake.sv
// Bench for ddr_cmd_intake: table vectors, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_ddr_cmd_intake;

  localparam int DATA_W   = 128;
  localparam int DEPTH    = 8;
  localparam int BANK_CAP = 4;
  localparam int ENT_W    = 34 + DATA_W;

  // Handshake: an entry leaves the queue on a rising edge where q_valid and
  // q_ready are both 1; a command enters where valid is 1 and its bank flag is 1.

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              power_on_rst_n = 1'b0;
  logic [33:0]       command = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              valid = 1'b0;
  logic [7:0]        ba_cmd_pm;
  logic              q_valid;
  logic              q_ready = 1'b0;
  logic [1:0]        q_rank;
  logic              q_write;
  logic [12:0]       q_row;
  logic [9:0]        q_col;
  logic [2:0]        q_bank;
  logic              q_bl8;
  logic              q_auto_pre;
  logic [DATA_W-1:0] q_wdata;
  logic [DATA_W-1:0] rdata_in = '0;
  logic              rdata_in_valid = 1'b0;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;
  logic [1:0]        cmd_err;

  always #5 clk = ~clk;

  ddr_cmd_intake #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BANK_CAP(BANK_CAP)) dut (
    .clk             (clk),
    .power_on_rst_n  (power_on_rst_n),
    .command         (command),
    .write_data      (write_data),
    .valid           (valid),
    .ba_cmd_pm       (ba_cmd_pm),
    .q_valid         (q_valid),
    .q_ready         (q_ready),
    .q_rank          (q_rank),
    .q_write         (q_write),
    .q_row           (q_row),
    .q_col           (q_col),
    .q_bank          (q_bank),
    .q_bl8           (q_bl8),
    .q_auto_pre      (q_auto_pre),
    .q_wdata         (q_wdata),
    .rdata_in        (rdata_in),
    .rdata_in_valid  (rdata_in_valid),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .cmd_err         (cmd_err)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [ENT_W-1:0]  exp_q[$];
  logic [1:0]        err_m = '0;
  logic [DATA_W-1:0] rd_m  = '0;
  logic              rdv_m = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] mk_cmd(input logic [1:0] rank, input logic rw,
                                         input logic [12:0] row, input logic [9:0] col,
                                         input logic [2:0] bank, input logic bl,
                                         input logic ap, input logic [2:0] rsv);
    return {rank, rw, rsv[2], row, rsv[1], bl, rsv[0], ap, col, bank};
  endfunction

  // A bank may accept while the queue has room and fewer than BANK_CAP of its commands are queued.
  function automatic logic [7:0] exp_pm();
    int cnt [8];
    logic [7:0] r;
    logic [ENT_W-1:0] e;
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    foreach (exp_q[i]) begin
      e = exp_q[i];
      cnt[e[DATA_W+2:DATA_W]]++;
    end
    for (int b = 0; b < 8; b++) r[b] = (exp_q.size() < DEPTH) && (cnt[b] < BANK_CAP);
    return r;
  endfunction

  task automatic check_model();
    logic [ENT_W-1:0] e;
    logic [33:0] hc;
    chk("ba_cmd_pm", ba_cmd_pm, exp_pm());
    chk("q_valid", q_valid, exp_q.size() > 0);
    chk("cmd_err", cmd_err, err_m);
    chk("read_data_valid", read_data_valid, rdv_m);
    chk("read_data", read_data, rd_m);
    if (exp_q.size() > 0) begin
      e  = exp_q[0];
      hc = e[DATA_W +: 34];
      chk("q_head_fields", {q_rank, q_write, q_row, q_col, q_bank, q_bl8, q_auto_pre},
          {hc[33:32], ~hc[31], hc[29:17], hc[12:3], hc[2:0], hc[15], hc[13]});
      chk("q_wdata", q_wdata, e[DATA_W-1:0]);
    end
  endtask

  task automatic update_model();
    logic [7:0] pm;
    pm = exp_pm();
    if (exp_q.size() > 0 && q_ready) void'(exp_q.pop_front());
    if (valid) begin
      if (pm[command[2:0]]) begin
        exp_q.push_back({command, command[31] ? {DATA_W{1'b0}} : write_data});
        if (command[30] | command[16] | command[14]) err_m[1] = 1'b1;
      end else begin
        err_m[0] = 1'b1;
      end
    end
    rd_m  = rdata_in;
    rdv_m = rdata_in_valid;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic v, input logic [33:0] c, input logic [DATA_W-1:0] wd,
                       input logic rdy, input logic [DATA_W-1:0] rdi, input logic rdvi);
    valid = v; command = c; write_data = wd; q_ready = rdy;
    rdata_in = rdi; rdata_in_valid = rdvi;
  endtask

  task automatic step();
    #1 check_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, '0, '0, 1'b0, '0, 1'b0);
      step();
    end
  endtask

  // Reset is asserted between edges to show it acts without a clock.
  task automatic do_reset();
    #2 power_on_rst_n = 1'b0;
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_ba_cmd_pm", ba_cmd_pm, 8'hFF);
    chk("rst_read_data_valid", read_data_valid, 1'b0);
    chk("rst_read_data", read_data, '0);
    chk("rst_cmd_err", cmd_err, 2'b00);
    exp_q.delete();
    err_m = '0; rd_m = '0; rdv_m = 1'b0;
    repeat (2) @(negedge clk);
    power_on_rst_n = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        v;
    logic [33:0] cmd;
    logic        rdy;
    logic [7:0]  exp_pm;
    logic        exp_qv;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [33:0] c;
    logic [DATA_W-1:0] a5;
    logic [2:0] bk;

    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b1, mk_cmd(2'd0, 1'b0, 13'(i + 1), 10'(i * 4), 3'd2, 1'b1, 1'b0, 3'b000),
                 1'b0, (i == 4) ? 8'hFB : 8'hFF, (i != 0), 2'b00};
    tbl[5] = '{1'b0, '0, 1'b0, 8'hFB, 1'b1, 2'b01};
    tbl[6] = '{1'b0, '0, 1'b1, 8'hFB, 1'b1, 2'b01};
    tbl[7] = '{1'b0, '0, 1'b0, 8'hFF, 1'b1, 2'b01};

    do_reset();

    // First write lands at the head one cycle later.
    a5 = {16{8'hA5}};
    apply(1'b1, mk_cmd(2'd0, 1'b0, 13'd5, 10'd8, 3'd0, 1'b1, 1'b0, 3'b000), a5, 1'b0, '0, 1'b0);
    step();
    chk("first_q_valid", q_valid, 1'b1);
    chk("first_q_row", q_row, 13'd5);
    chk("first_q_col", q_col, 10'd8);
    chk("first_q_write", q_write, 1'b1);
    chk("first_q_bl8", q_bl8, 1'b1);
    chk("first_q_wdata", q_wdata, a5);
    chk("first_ba_cmd_pm", ba_cmd_pm, 8'hFF);

    // Bank cap and drop via the table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].cmd, DATA_W'(i * 32'h1111_0001), tbl[i].rdy, '0, 1'b0);
      #1;
      chk($sformatf("tbl%0d_ba_cmd_pm", i), ba_cmd_pm, tbl[i].exp_pm);
      chk($sformatf("tbl%0d_q_valid", i), q_valid, tbl[i].exp_qv);
      chk($sformatf("tbl%0d_cmd_err", i), cmd_err, tbl[i].exp_err);
      step();
    end

    // Fill all eight entries across banks, then free one slot.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, mk_cmd(2'(i), 1'(i % 2), 13'(100 + i), 10'(i), 3'(i), 1'(i % 3 == 0), 1'(i % 2), 3'b000),
            {4{$urandom}}, 1'b0, '0, 1'b0);
      step();
    end
    chk("full_ba_cmd_pm", ba_cmd_pm, 8'h00);
    apply(1'b0, '0, '0, 1'b1, '0, 1'b0);
    step();
    chk("after_pop_ba_cmd_pm", ba_cmd_pm, 8'hFF);
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, '0, '0, 1'b1, '0, 1'b0);
      step();
    end
    chk("drained_q_valid", q_valid, 1'b0);

    // Push and pop to bank 3 in the same cycle leaves its count unchanged.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, mk_cmd(2'd1, 1'b0, 13'(i), 10'(i), 3'd3, 1'b0, 1'b1, 3'b000),
            {4{$urandom}}, (i == 2), '0, 1'b0);
      step();
      if (i == 3) chk("bank3_cnt3_flag", ba_cmd_pm[3], 1'b1);
    end
    chk("bank3_cap_flag", ba_cmd_pm[3], 1'b0);
    chk("bank3_others", ba_cmd_pm[7:4], 4'hF);

    // Reserved bit on a read, plus the read return path.
    do_reset();
    apply(1'b1, mk_cmd(2'd2, 1'b1, 13'd7, 10'd9, 3'd5, 1'b0, 1'b0, 3'b100),
          {4{32'hDEAD_BEEF}}, 1'b0, DATA_W'(16'h1234), 1'b1);
    step();
    chk("rsvd_q_wdata", q_wdata, '0);
    chk("rsvd_cmd_err", cmd_err, 2'b10);
    chk("rd_data", read_data, DATA_W'(16'h1234));
    chk("rd_valid", read_data_valid, 1'b1);
    apply(1'b0, '0, '0, 1'b0, '0, 1'b0);
    step();
    chk("rd_valid_drop", read_data_valid, 1'b0);

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, mk_cmd(2'd0, 1'b0, 13'(i), 10'(i), 3'(i), 1'b1, 1'b0, 3'b000),
            {4{$urandom}}, 1'b0, DATA_W'(32'hCAFE_0000 + i), 1'b1);
      step();
    end
    chk("pre_rst_read_data_valid", read_data_valid, 1'b1);
    do_reset();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      bk = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      c  = mk_cmd(2'($urandom), 1'($urandom), 13'($urandom), 10'($urandom), bk,
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000);
      apply($urandom_range(0, 3) != 0, c, {$urandom, $urandom, $urandom, $urandom},
            (n < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      step();
      if (n == 1000) do_reset();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
